// File: rtl/seg_scan_bank.sv
// seg_scan_bank
// Bank of NUM_DIG segment-pattern registers plus a time-multiplexed scan
// driver for a multi-digit 7-segment display.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   we, waddr, wdata      addressed pattern write (waddr >= NUM_DIG ignored)
//   clr                   clear every pattern register (wins over we)
//   blank                 force display dark (scan keeps running)
//   blink_mask            per-digit blink enable (SEG_BLINK_EN builds only)
//   seg_out               registered pattern of the scanned digit
//   an_out                registered one-hot digit select, AN_ACT_LOW polarity
//   dig_idx               current scan index
//   tick                  one-cycle pulse after dig_idx advances
//
// Optional feature macro: SEG_BLINK_EN adds blink_mask and BLINK_DIV.
// A phase bit toggles every BLINK_DIV complete frames and darkens the
// masked digits while set.

module seg_scan_bank #(
  parameter int NUM_DIG    = 4,
  parameter int SEG_W      = 8,
  parameter int PRESC      = 50000,
  parameter int AN_ACT_LOW = 1
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_DIV  = 32
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(NUM_DIG)-1:0] waddr,
  input  logic [SEG_W-1:0]           wdata,
  input  logic                       clr,
  input  logic                       blank,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIG-1:0]         blink_mask,
`endif
  output logic [SEG_W-1:0]           seg_out,
  output logic [NUM_DIG-1:0]         an_out,
  output logic [$clog2(NUM_DIG)-1:0] dig_idx,
  output logic                       tick
);

  localparam int AW = $clog2(NUM_DIG);
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(PRESC - 1);
  localparam logic [AW-1:0]      DIG_LAST   = AW'(NUM_DIG - 1);
  localparam logic [NUM_DIG-1:0] AN_OFF     = {NUM_DIG{AN_ACT_LOW != 0}};

  logic [SEG_W-1:0]   pat_q [NUM_DIG];
  logic [SEG_W-1:0]   pat_d [NUM_DIG];
  logic [PW-1:0]      presc_q, presc_d;
  logic [AW-1:0]      dig_idx_q, dig_idx_d;
  logic               tick_q, tick_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [NUM_DIG-1:0] an_q, an_d;

  logic               slot_end;
  logic [SEG_W-1:0]   cur_pat;
  logic [NUM_DIG-1:0] onehot;
  logic               dark;

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    // A frame completes when the scan wraps from the last digit back to 0.
    if (slot_end && (dig_idx_q == DIG_LAST)) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end
`endif

  always_comb begin
    // Pattern registers: clr dominates we; out-of-range addresses match no slot.
    for (int i = 0; i < NUM_DIG; i++) begin
      pat_d[i] = pat_q[i];
      if (clr) begin
        pat_d[i] = '0;
      end else if (we && (waddr == AW'(i))) begin
        pat_d[i] = wdata;
      end
    end

    slot_end = (presc_q == PRESC_LAST);
    presc_d  = slot_end ? '0 : presc_q + PW'(1);

    dig_idx_d = dig_idx_q;
    if (slot_end) begin
      dig_idx_d = (dig_idx_q == DIG_LAST) ? '0 : dig_idx_q + AW'(1);
    end
    tick_d = slot_end;

    cur_pat = '0;
    onehot  = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (dig_idx_q == AW'(i)) begin
        cur_pat   = pat_q[i];
        onehot[i] = 1'b1;
      end
    end

    dark = blank;
`ifdef SEG_BLINK_EN
    dark = blank || (phase_q && (|(blink_mask & onehot)));
`endif

    // seg and an are registered together from the same dig_idx so the
    // pattern and its anode always switch on the same edge.
    seg_d = dark ? '0 : cur_pat;
    if (dark) begin
      an_d = AN_OFF;
    end else begin
      an_d = (AN_ACT_LOW != 0) ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        pat_q[i] <= '0;
      end
      presc_q   <= '0;
      dig_idx_q <= '0;
      tick_q    <= 1'b0;
      seg_q     <= '0;
      an_q      <= AN_OFF;
    end else begin
      for (int i = 0; i < NUM_DIG; i++) begin
        pat_q[i] <= pat_d[i];
      end
      presc_q   <= presc_d;
      dig_idx_q <= dig_idx_d;
      tick_q    <= tick_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign an_out  = an_q;
  assign dig_idx = dig_idx_q;
  assign tick    = tick_q;

endmodule

// File: doc/seg_scan_bank.md
Name: seg_scan_bank

Overview:
Parametrised bank of NUM_DIG segment-pattern registers with a built-in time-multiplexed scan driver for a common-anode/cathode multi-digit 7-segment display. Successor to the single enabled segment register: adds addressed writes, bulk clear, refresh prescaler, digit scanning, blanking and defined reset priority. Sits between the display-formatting logic (decoders, time/date formatter) and the board seg/anode pins.

Parameters:
NUM_DIG, 4, number of digits / pattern registers (2..16)
SEG_W, 8, pattern width (7 segments + dp)
PRESC, 50000, clk cycles per digit slot (>=1)
AN_ACT_LOW, 1, 1 = anode outputs active-low, 0 = active-high

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
we  in  1  write enable for pattern register
waddr  in  $clog2(NUM_DIG)  digit index to write
wdata  in  SEG_W  pattern to store
clr  in  1  clear all pattern registers
blank  in  1  force display dark
seg_out  out  SEG_W  registered pattern for active digit
an_out  out  NUM_DIG  registered one-hot digit select, polarity per AN_ACT_LOW
dig_idx  out  $clog2(NUM_DIG)  current scan index
tick  out  1  one-cycle pulse when dig_idx advances

Behaviour:
- Clock clk; reset synchronous, active-high, sampled on posedge clk.
- Priority per edge: reset > clr > we. Reset dominates every other input, including we.
- Reset values: all pattern regs 0, seg_out 0, an_out all inactive (all 1 if AN_ACT_LOW else all 0), dig_idx 0, prescaler 0, tick 0.
- Write: we=1 and waddr<NUM_DIG -> reg[waddr]<=wdata at the edge. waddr>=NUM_DIG is ignored with no side effects.
- clr=1: all regs <= 0 in one cycle. A coincident we is discarded.
- Prescaler: counts 0..PRESC-1 and wraps to 0. On the edge where count==PRESC-1:
  - dig_idx <= (dig_idx==NUM_DIG-1) ? 0 : dig_idx+1
  - tick registered high for exactly the following cycle.
  - PRESC=1: dig_idx advances and tick is high every cycle.
- Output stage, registered each edge from the current dig_idx and regs:
  - seg_out <= reg[dig_idx]
  - an_out <= one-hot(dig_idx), polarity-applied.
  - seg_out/an_out therefore lag dig_idx by 1 cycle and always change on the same edge (no ghosting mismatch).
- Write latency: a write to the displayed digit at edge k is visible on seg_out after edge k+1.
- blank=1: at the next edge seg_out<=0 and an_out<=all inactive. Prescaler and dig_idx keep running. On deassert, output resumes from the current dig_idx one cycle later.
- Scanning and writes are independent; simultaneous write and digit advance are both honoured.
- Reset mid-scan: the next cycle is the full reset state and scan restarts at digit 0.

Optional Feature:
SEG_BLINK_EN
- Defined:
  - Adds input blink_mask [NUM_DIG] and parameter BLINK_DIV (default 32).
  - A phase bit toggles after every BLINK_DIV complete frames (dig_idx wrap from NUM_DIG-1 to 0); reset clears phase and the frame counter.
  - While phase=1 and blink_mask[dig_idx]=1, that slot outputs seg_out=0 and an_out inactive. Other digits are unaffected.
  - blank overrides blink.
- Undefined: no port, no counter, no phase logic; behaviour exactly as above.

Test Plan:
- Setup for all tests: NUM_DIG=4, PRESC=4, AN_ACT_LOW=1.
- Reset for 2 cycles -> seg_out=0x00, an_out=4'b1111, dig_idx=0, tick=0. Hold we=1 with wdata=0xFF during reset -> regs remain 0 afterwards.
- Write 0x06 to addr 0 and 0x3F to addr 2, then run 16 cycles -> tick every 4 cycles; dig_idx sequence 0,1,2,3,0; seg_out=0x06 with an_out=1110 in slot 0; seg_out=0x3F with an_out=1011 in slot 2; seg_out=0x00 in slots 1 and 3.
- Assert clr and we (addr 1, 0x5B) in the same cycle -> all slots show 0x00 over the next frame.
- Assert blank for 10 cycles -> an_out=1111 and seg_out=0 from the next edge; dig_idx keeps advancing; after deassert, correct patterns return within 1 cycle.
- NUM_DIG=6, write addr 7 with 0x7F -> ignored, all 6 slots unchanged. PRESC=1 -> dig_idx advances every cycle.
- SEG_BLINK_EN, BLINK_DIV=1, blink_mask=4'b0100 -> digit 2 dark on alternate frames; digits 0, 1, 3 lit every frame.
